pe_job_scheduler: RTL and testbench

Round-robin scheduler that shares the single PE datapath between `NUM_REQ` job requesters, such as instruction-driven control units and a host/DMA port. Each requester submits a burst job (base address, length). The scheduler grants one job at a time and sequences `mem_addr`/`pe_valid`/`pe_last` beats into the PE array. When the job's last beat is accepted, it returns a per-requester `done` pulse. It sits between the control units and the PE array/operand memory.

---
 rtl/pe_sched_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/pe_job_scheduler.sv | 151 +++++++++++++++
 tb/tb_pe_job_scheduler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pe_sched_pkg.sv
// Shared types and default widths for the PE job scheduler and its control units.
package pe_sched_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } sched_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_LEN_WIDTH  = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first valid requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [2*NUM_REQ-1:0] rot_dbl;
  logic [2*NUM_REQ-1:0] unrot_dbl;
  logic [NUM_REQ-1:0]   rot_vec;
  logic [NUM_REQ-1:0]   rot_first;
  logic [IDX_W-1:0]     idx_terms [NUM_REQ];

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, then rotate back.
  assign rot_dbl   = {req_valid, req_valid} >> ptr;
  assign rot_vec   = rot_dbl[NUM_REQ-1:0];
  assign rot_first = rot_vec & ~(rot_vec - NUM_REQ'(1));
  assign unrot_dbl = {rot_first, rot_first} << ptr;
  assign grant     = unrot_dbl[2*NUM_REQ-1:NUM_REQ];
  assign grant_any = |req_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_idx
      assign idx_terms[gi] = grant[gi] ? IDX_W'(gi) : '0;
    end
  endgenerate

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_idx = grant_idx | idx_terms[i];
    end
  end

endmodule

// File: rtl/pe_job_scheduler.sv
// Round-robin job scheduler feeding burst beats into the PE array.
// Optional feature macro: PE_SCHED_PERF_EN adds the stall_cycles counter output.
module pe_job_scheduler
  import pe_sched_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_base,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_REQ-1:0]              done,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic                            pe_valid,
  output logic                            pe_last,
  input  logic                            pe_ready,
  output logic [IDX_W-1:0]                pe_owner,
  output logic                            busy
`ifdef PE_SCHED_PERF_EN
  ,
  output logic [31:0]                     stall_cycles
`endif
);

  localparam logic [0:0] ST_IDLE = S_IDLE;
  localparam logic [0:0] ST_RUN  = S_RUN;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic [0:0]             state_reg;
  logic [IDX_W-1:0]       ptr_reg;
  logic [IDX_W-1:0]       owner_reg;
  logic [LEN_WIDTH-1:0]   len_reg;
  logic [LEN_WIDTH-1:0]   cnt_reg;
  logic [ADDR_WIDTH-1:0]  mem_addr_reg;
  logic                   pe_last_reg;
  logic [NUM_REQ-1:0]     done_reg;

  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;
  logic [IDX_W-1:0]       ptr_next;
  logic [LEN_WIDTH-1:0]   cnt_next;
  logic [ADDR_WIDTH-1:0]  sel_base;
  logic [LEN_WIDTH-1:0]   sel_len;
  logic [NUM_REQ-1:0]     owner_onehot;
  logic [ADDR_WIDTH-1:0]  base_arr [NUM_REQ];
  logic [LEN_WIDTH-1:0]   len_arr  [NUM_REQ];
  logic                   in_idle;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign base_arr[gi]     = req_base[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign len_arr[gi]      = req_len[gi*LEN_WIDTH +: LEN_WIDTH];
      assign owner_onehot[gi] = (owner_reg == IDX_W'(gi));
    end
  endgenerate

  assign sel_base = base_arr[grant_idx];
  assign sel_len  = len_arr[grant_idx];
  assign ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
  assign cnt_next = cnt_reg + LEN_ONE;
  assign in_idle  = (state_reg == ST_IDLE);

  // Accept is the only combinational output; held off while reset is asserted.
  assign req_ready = (in_idle && rst_n) ? grant : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      len_reg      <= '0;
      cnt_reg      <= '0;
      mem_addr_reg <= '0;
      pe_last_reg  <= 1'b0;
      done_reg     <= '0;
    end else begin
      done_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_any) begin
            ptr_reg      <= ptr_next;
            owner_reg    <= grant_idx;
            len_reg      <= sel_len;
            cnt_reg      <= '0;
            mem_addr_reg <= sel_base;
            if (sel_len == '0) begin
              done_reg <= grant;
            end else begin
              state_reg   <= ST_RUN;
              pe_last_reg <= (sel_len == LEN_ONE);
            end
          end
        end
        default: begin
          if (pe_ready) begin
            if (pe_last_reg) begin
              state_reg   <= ST_IDLE;
              pe_last_reg <= 1'b0;
              done_reg    <= owner_onehot;
            end else begin
              cnt_reg      <= cnt_next;
              mem_addr_reg <= mem_addr_reg + ADDR_ONE;
              pe_last_reg  <= (cnt_next == len_reg - LEN_ONE);
            end
          end
        end
      endcase
    end
  end

  assign busy     = (state_reg == ST_RUN);
  assign pe_valid = busy;
  assign pe_last  = pe_last_reg;
  assign mem_addr = mem_addr_reg;
  assign pe_owner = owner_reg;
  assign done     = done_reg;

`ifdef PE_SCHED_PERF_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (busy && !pe_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pe_job_scheduler.sv
// Directed self-checking bench for pe_job_scheduler (default parameters).
module tb_pe_job_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_base;
  logic [31:0] req_len;
  logic [3:0]  done;
  logic [7:0]  mem_addr;
  logic        pe_valid;
  logic        pe_last;
  logic        pe_ready;
  logic [1:0]  pe_owner;
  logic        busy;
`ifdef PE_SCHED_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pe_job_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_base  (req_base),
    .req_len   (req_len),
    .done      (done),
    .mem_addr  (mem_addr),
    .pe_valid  (pe_valid),
    .pe_last   (pe_last),
    .pe_ready  (pe_ready),
    .pe_owner  (pe_owner),
    .busy      (busy)
`ifdef PE_SCHED_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input int base, input int len);
    req_base[r*8 +: 8] = 8'(base);
    req_len[r*8 +: 8]  = 8'(len);
    req_valid[r]       = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    check({tag, "_done"},      32'(done),      32'h0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
    check({tag, "_pe_valid"},  32'(pe_valid),  32'h0);
    check({tag, "_pe_last"},   32'(pe_last),   32'h0);
    check({tag, "_pe_owner"},  32'(pe_owner),  32'h0);
    check({tag, "_busy"},      32'(busy),      32'h0);
`ifdef PE_SCHED_PERF_EN
    check({tag, "_stall"},     stall_cycles,   32'h0);
`endif
  endtask

  // Called in the accept cycle; returns in the done cycle.
  task automatic run_job(input string tag, input int owner, input int base, input int len,
                         input int stall_beat, input int stall_n);
    logic [7:0] a;
    #1;
    check({tag, "_accept"}, 32'(req_ready), 32'(1 << owner));
    step();
    req_valid[owner] = 1'b0;
    for (int i = 0; i < len; i++) begin
      a = 8'(base + i);
      if (i == stall_beat) begin
        pe_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          #1;
          check({tag, "_hold_addr"},  32'(mem_addr), 32'(a));
          check({tag, "_hold_valid"}, 32'(pe_valid), 32'h1);
          check({tag, "_hold_last"},  32'(pe_last),  32'(i == len - 1));
          step();
        end
        pe_ready = 1'b1;
      end
      check({tag, "_addr"},  32'(mem_addr),  32'(a));
      check({tag, "_valid"}, 32'(pe_valid),  32'h1);
      check({tag, "_last"},  32'(pe_last),   32'(i == len - 1));
      check({tag, "_owner"}, 32'(pe_owner),  32'(owner));
      check({tag, "_busy"},  32'(busy),      32'h1);
      check({tag, "_nodone"}, 32'(done),     32'h0);
      check({tag, "_noready"}, 32'(req_ready), 32'h0);
      step();
    end
    check({tag, "_done"},     32'(done),     32'(1 << owner));
    check({tag, "_idle"},     32'(busy),     32'h0);
    check({tag, "_novalid"},  32'(pe_valid), 32'h0);
    $display("job %s: owner=%0d base=0x%02h len=%0d complete", tag, owner, base, len);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_base  = '0;
    req_len   = '0;
    pe_ready  = 1'b1;
    do_reset();
    check_reset_outputs("rst");

    // Single job on requester 0
    set_req(0, 'h10, 4);
    run_job("single", 0, 'h10, 4, -1, 0);
    step();
    check("single_done_pulse", 32'(done), 32'h0);

    // All four valid from reset: grant order 0,1,2,3 then 0 again
    do_reset();
    set_req(0, 'h20, 2);
    set_req(1, 'h40, 2);
    set_req(2, 'h60, 2);
    set_req(3, 'h80, 2);
    run_job("rr0", 0, 'h20, 2, -1, 0);
    run_job("rr1", 1, 'h40, 2, -1, 0);
    run_job("rr2", 2, 'h60, 2, -1, 0);
    run_job("rr3", 3, 'h80, 2, -1, 0);
    set_req(0, 'h24, 2);
    run_job("rr4", 0, 'h24, 2, -1, 0);

    // Address wrap on requester 2
    set_req(2, 'hFE, 4);
    run_job("wrap", 2, 'hFE, 4, -1, 0);

    // Backpressure on beat 1 for two cycles
    set_req(1, 'h30, 3);
    run_job("stall", 1, 'h30, 3, 1, 2);
`ifdef PE_SCHED_PERF_EN
    check("stall_cycles", stall_cycles, 32'd2);
`endif

    // Zero-length job then a single-beat job
    set_req(3, 'h55, 0);
    run_job("zero", 3, 'h55, 0, -1, 0);
    step();
    check("zero_done_once", 32'(done), 32'h0);
    set_req(0, 'h77, 1);
    run_job("one", 0, 'h77, 1, -1, 0);

    // Reset during beat 2 of a len=5 job on requester 2
    step();
    set_req(2, 'h90, 5);
    #1;
    check("abort_accept", 32'(req_ready), 32'h4);
    step();
    req_valid[2] = 1'b0;
    step();
    step();
    check("abort_beat2", 32'(mem_addr), 32'h92);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset_outputs("abort");
    step();
    check("abort_no_done", 32'(done), 32'h0);
    check("abort_still_idle", 32'(busy), 32'h0);
    $display("abort: job cut by reset, no done observed");

    // ptr back at 0: requester 1 must win over 3
    set_req(1, 'hA0, 1);
    set_req(3, 'hB0, 1);
    run_job("post1", 1, 'hA0, 1, -1, 0);
    run_job("post3", 3, 'hB0, 1, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
